// File: rtl/flex_cnt_pkg.sv
// Shared types and default widths for the flexible up/down counter and its prescaler.
package flex_cnt_pkg;

  typedef enum logic {MODE_WRAP = 1'b0, MODE_SAT = 1'b1} mode_t;
  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

  localparam int DEF_CNT_BITS      = 4;
  localparam int DEF_STEP_BITS     = 2;
  localparam int DEF_PRESCALE_BITS = 4;

endpackage

// File: rtl/flex_prescaler.sv
// Enable divider for flex_updown_counter: emits a tick on every (prescale_val+1)-th
// enabled cycle. Instantiated only when FLEX_CNT_PRESCALE_EN is defined.
module flex_prescaler
  import flex_cnt_pkg::*;
#(
  parameter int PRESCALE_BITS = DEF_PRESCALE_BITS
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     clear,
  input  logic                     enable,
  input  logic [PRESCALE_BITS-1:0] prescale_val,
  output logic                     tick
);

  logic [PRESCALE_BITS-1:0] pre_q;

  // >= rather than == so a divider lowered mid-period still terminates the period.
  assign tick = enable && (pre_q >= prescale_val);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pre_q <= '0;
    end else if (clear) begin
      pre_q <= '0;
    end else if (enable) begin
      pre_q <= tick ? '0 : pre_q + 1'b1;
    end
  end

endmodule

// File: rtl/flex_updown_counter.sv
// Bounded up/down counter with programmable step, wrap/saturate mode and registered
// boundary flags. Define FLEX_CNT_PRESCALE_EN to add the prescale_val divider.
module flex_updown_counter
  import flex_cnt_pkg::*;
#(
  parameter int NUM_CNT_BITS  = DEF_CNT_BITS,
  parameter int STEP_BITS     = DEF_STEP_BITS,
  parameter int PRESCALE_BITS = DEF_PRESCALE_BITS
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     clear,
  input  logic                     load,
  input  logic [NUM_CNT_BITS-1:0]  load_val,
  input  logic                     count_enable,
  input  logic                     count_down,
  input  logic                     mode,
  input  logic [STEP_BITS-1:0]     step,
  input  logic [NUM_CNT_BITS-1:0]  floor_val,
  input  logic [NUM_CNT_BITS-1:0]  rollover_val,
`ifdef FLEX_CNT_PRESCALE_EN
  input  logic [PRESCALE_BITS-1:0] prescale_val,
`endif
  output logic [NUM_CNT_BITS-1:0]  count_out,
  output logic                     rollover_flag,
  output logic                     floor_flag,
  output logic                     wrap_pulse,
  output logic                     cfg_err
);

  // Two guard bits: one for up-count overflow, one as sign for down-count underflow.
  localparam int EW = ((NUM_CNT_BITS > STEP_BITS) ? NUM_CNT_BITS : STEP_BITS) + 2;

  if (NUM_CNT_BITS < 1 || STEP_BITS < 1 || PRESCALE_BITS < 1) begin : g_param_check
    $error("flex_updown_counter: all widths must be at least 1");
  end

  logic [NUM_CNT_BITS-1:0] count_q, count_d;
  logic                    rollover_flag_q, floor_flag_q, wrap_pulse_q, cfg_err_q;
  logic                    wrap_d;
  logic                    cfg_bad, advance;
  mode_t                   mode_s;
  dir_t                    dir_s;
  logic signed [EW-1:0]    cnt_x, step_x, floor_x, roll_x, sum_x, diff_x;

  assign mode_s  = mode_t'(mode);
  assign dir_s   = dir_t'(count_down);
  assign cfg_bad = floor_val > rollover_val;

`ifdef FLEX_CNT_PRESCALE_EN
  flex_prescaler #(
    .PRESCALE_BITS(PRESCALE_BITS)
  ) u_prescaler (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (clear | load),
    .enable       (count_enable & ~cfg_bad),
    .prescale_val (prescale_val),
    .tick         (advance)
  );
`else
  assign advance = count_enable & ~cfg_bad;
`endif

  assign cnt_x   = $signed({{(EW-NUM_CNT_BITS){1'b0}}, count_q});
  assign step_x  = $signed({{(EW-STEP_BITS){1'b0}}, step});
  assign floor_x = $signed({{(EW-NUM_CNT_BITS){1'b0}}, floor_val});
  assign roll_x  = $signed({{(EW-NUM_CNT_BITS){1'b0}}, rollover_val});
  assign sum_x   = cnt_x + step_x;
  assign diff_x  = cnt_x - step_x;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (advance && step != '0) begin
      if (dir_s == DIR_UP) begin
        if (sum_x > roll_x) begin
          wrap_d  = 1'b1;
          count_d = (mode_s == MODE_WRAP) ? floor_val : rollover_val;
        end else begin
          count_d = sum_x[NUM_CNT_BITS-1:0];
        end
      end else begin
        if (diff_x < floor_x) begin
          wrap_d  = 1'b1;
          count_d = (mode_s == MODE_WRAP) ? rollover_val : floor_val;
        end else begin
          count_d = diff_x[NUM_CNT_BITS-1:0];
        end
      end
    end
  end

  // Flags compare the next count so they line up with count_out.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q         <= '0;
      rollover_flag_q <= 1'b0;
      floor_flag_q    <= 1'b0;
      wrap_pulse_q    <= 1'b0;
      cfg_err_q       <= 1'b0;
    end else begin
      count_q         <= count_d;
      rollover_flag_q <= (count_d == rollover_val);
      floor_flag_q    <= (count_d == floor_val);
      wrap_pulse_q    <= wrap_d;
      cfg_err_q       <= cfg_bad;
    end
  end

  assign count_out     = count_q;
  assign rollover_flag = rollover_flag_q;
  assign floor_flag    = floor_flag_q;
  assign wrap_pulse    = wrap_pulse_q;
  assign cfg_err       = cfg_err_q;

endmodule

// File: tb/tb_flex_updown_counter.sv
// Scoreboard bench for flex_updown_counter: expected {count, rf, ff, wp, ce} tuples are
// queued as stimulus is driven and popped after each edge. Prescale test needs FLEX_CNT_PRESCALE_EN.
module tb_flex_updown_counter;
  import flex_cnt_pkg::*;

  localparam int N  = 4;
  localparam int SB = 2;
  localparam int PB = 4;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          clear, load, count_enable, count_down, mode;
  logic [N-1:0]  load_val, floor_val, rollover_val;
  logic [SB-1:0] step;
  logic [PB-1:0] prescale_val;
  logic [N-1:0]  count_out;
  logic          rollover_flag, floor_flag, wrap_pulse, cfg_err;

  logic [7:0] exp_q[$];
  logic [7:0] got_v, exp_v;
  int         n_cmp = 0;
  int         n_mis = 0;

  always #5 clk = ~clk;

  flex_updown_counter #(
    .NUM_CNT_BITS (N),
    .STEP_BITS    (SB),
    .PRESCALE_BITS(PB)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (clear),
    .load         (load),
    .load_val     (load_val),
    .count_enable (count_enable),
    .count_down   (count_down),
    .mode         (mode),
    .step         (step),
    .floor_val    (floor_val),
    .rollover_val (rollover_val),
`ifdef FLEX_CNT_PRESCALE_EN
    .prescale_val (prescale_val),
`endif
    .count_out    (count_out),
    .rollover_flag(rollover_flag),
    .floor_flag   (floor_flag),
    .wrap_pulse   (wrap_pulse),
    .cfg_err      (cfg_err)
  );

  function automatic logic [7:0] mk(input int c, input bit rf, input bit ff, input bit wp, input bit ce);
    logic [31:0] cv;
    cv = c;
    return {cv[3:0], rf, ff, wp, ce};
  endfunction

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_rst = 1'b0; clear = 1'b0; load = 1'b0; load_val = '0;
    count_enable = 1'b1; count_down = DIR_UP; mode = MODE_WRAP; step = 2'd1;
    floor_val = 4'd1; rollover_val = 4'd5; prescale_val = '0;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(mk(0, 0, 0, 0, 0));
      if (k == 0) #2; else next_edge();
      got_v = {count_out, rollover_flag, floor_flag, wrap_pulse, cfg_err};
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (got_v !== exp_v) begin
        n_mis++;
        $display("FAIL reset[%0d]: got cnt=%0d rf/ff/wp/ce=%b, expected cnt=%0d rf/ff/wp/ce=%b",
                 k, got_v[7:4], got_v[3:0], exp_v[7:4], exp_v[3:0]);
      end else $display("reset[%0d] cnt=%0d flags=%b", k, got_v[7:4], got_v[3:0]);
    end
    n_rst = 1'b1;
  endtask

  task automatic test_legacy();
    for (int i = 0; i < 12; i++) begin
      int c;
      c = (i % 5) + 1;
      exp_q.push_back(mk(c, c == 5, c == 1, (c == 1) && (i > 0), 0));
    end
    for (int k = 0; k < 12; k++) begin
      next_edge();
      got_v = {count_out, rollover_flag, floor_flag, wrap_pulse, cfg_err};
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (got_v !== exp_v) begin
        n_mis++;
        $display("FAIL legacy[%0d]: got cnt=%0d rf/ff/wp/ce=%b, expected cnt=%0d rf/ff/wp/ce=%b",
                 k, got_v[7:4], got_v[3:0], exp_v[7:4], exp_v[3:0]);
      end else $display("legacy[%0d] cnt=%0d flags=%b", k, got_v[7:4], got_v[3:0]);
    end
  endtask

  task automatic test_overshoot();
    rollover_val = 4'd10; floor_val = 4'd2; step = 2'd3; count_down = DIR_UP; load_val = 4'd2;
    exp_q.push_back(mk(2, 0, 1, 0, 0));
    exp_q.push_back(mk(5, 0, 0, 0, 0));
    exp_q.push_back(mk(8, 0, 0, 0, 0));
    exp_q.push_back(mk(2, 0, 1, 1, 0));
    exp_q.push_back(mk(2, 0, 1, 0, 0));
    exp_q.push_back(mk(5, 0, 0, 0, 0));
    exp_q.push_back(mk(8, 0, 0, 0, 0));
    exp_q.push_back(mk(10, 1, 0, 1, 0));
    exp_q.push_back(mk(10, 1, 0, 1, 0));
    for (int k = 0; k < 9; k++) begin
      load = (k == 0) || (k == 4);
      count_enable = !load;
      mode = (k >= 4) ? MODE_SAT : MODE_WRAP;
      next_edge();
      got_v = {count_out, rollover_flag, floor_flag, wrap_pulse, cfg_err};
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (got_v !== exp_v) begin
        n_mis++;
        $display("FAIL overshoot[%0d]: got cnt=%0d rf/ff/wp/ce=%b, expected cnt=%0d rf/ff/wp/ce=%b",
                 k, got_v[7:4], got_v[3:0], exp_v[7:4], exp_v[3:0]);
      end else $display("overshoot[%0d] cnt=%0d flags=%b", k, got_v[7:4], got_v[3:0]);
    end
    load = 1'b0;
  endtask

  task automatic test_down();
    floor_val = 4'd3; rollover_val = 4'd9; step = 2'd2; count_down = DIR_DOWN; load_val = 4'd7;
    exp_q.push_back(mk(7, 0, 0, 0, 0));
    exp_q.push_back(mk(5, 0, 0, 0, 0));
    exp_q.push_back(mk(3, 0, 1, 0, 0));
    exp_q.push_back(mk(9, 1, 0, 1, 0));
    exp_q.push_back(mk(7, 0, 0, 0, 0));
    exp_q.push_back(mk(5, 0, 0, 0, 0));
    exp_q.push_back(mk(3, 0, 1, 0, 0));
    exp_q.push_back(mk(3, 0, 1, 1, 0));
    exp_q.push_back(mk(3, 0, 1, 1, 0));
    for (int k = 0; k < 9; k++) begin
      load = (k == 0) || (k == 4);
      count_enable = !load;
      mode = (k >= 4) ? MODE_SAT : MODE_WRAP;
      next_edge();
      got_v = {count_out, rollover_flag, floor_flag, wrap_pulse, cfg_err};
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (got_v !== exp_v) begin
        n_mis++;
        $display("FAIL down[%0d]: got cnt=%0d rf/ff/wp/ce=%b, expected cnt=%0d rf/ff/wp/ce=%b",
                 k, got_v[7:4], got_v[3:0], exp_v[7:4], exp_v[3:0]);
      end else $display("down[%0d] cnt=%0d flags=%b", k, got_v[7:4], got_v[3:0]);
    end
    load = 1'b0;
  endtask

  task automatic test_priority();
    load_val = 4'd6;
    exp_q.push_back(mk(0, 0, 0, 0, 0));
    exp_q.push_back(mk(6, 0, 0, 0, 0));
    exp_q.push_back(mk(6, 0, 0, 0, 0));
    exp_q.push_back(mk(4, 0, 0, 0, 0));
    exp_q.push_back(mk(0, 0, 0, 0, 0));
    for (int k = 0; k < 5; k++) begin
      clear = (k == 0) || (k == 4);
      load = (k <= 1);
      count_enable = (k <= 3);
      step = (k == 2) ? 2'd0 : 2'd2;
      next_edge();
      got_v = {count_out, rollover_flag, floor_flag, wrap_pulse, cfg_err};
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (got_v !== exp_v) begin
        n_mis++;
        $display("FAIL priority[%0d]: got cnt=%0d rf/ff/wp/ce=%b, expected cnt=%0d rf/ff/wp/ce=%b",
                 k, got_v[7:4], got_v[3:0], exp_v[7:4], exp_v[3:0]);
      end else $display("priority[%0d] cnt=%0d flags=%b", k, got_v[7:4], got_v[3:0]);
    end
    clear = 1'b0; load = 1'b0;
  endtask

  task automatic test_cfg_err();
    floor_val = 4'd8; rollover_val = 4'd4; step = 2'd1; count_down = DIR_UP; mode = MODE_WRAP;
    load_val = 4'd2;
    exp_q.push_back(mk(0, 0, 0, 0, 1));
    exp_q.push_back(mk(0, 0, 0, 0, 1));
    exp_q.push_back(mk(2, 0, 0, 0, 1));
    exp_q.push_back(mk(3, 0, 0, 0, 0));
    exp_q.push_back(mk(4, 1, 0, 0, 0));
    exp_q.push_back(mk(4, 1, 1, 1, 0));
    exp_q.push_back(mk(4, 1, 1, 1, 0));
    for (int k = 0; k < 7; k++) begin
      load = (k == 2);
      count_enable = (k != 2);
      if (k == 3) floor_val = 4'd1;
      if (k == 5) floor_val = 4'd4;
      next_edge();
      got_v = {count_out, rollover_flag, floor_flag, wrap_pulse, cfg_err};
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (got_v !== exp_v) begin
        n_mis++;
        $display("FAIL cfg_err[%0d]: got cnt=%0d rf/ff/wp/ce=%b, expected cnt=%0d rf/ff/wp/ce=%b",
                 k, got_v[7:4], got_v[3:0], exp_v[7:4], exp_v[3:0]);
      end else $display("cfg_err[%0d] cnt=%0d flags=%b", k, got_v[7:4], got_v[3:0]);
    end
    load = 1'b0;
  endtask

  task automatic test_reset_mid();
    floor_val = 4'd1; rollover_val = 4'd9; step = 2'd1; count_enable = 1'b1;
    exp_q.push_back(mk(5, 0, 0, 0, 0));
    exp_q.push_back(mk(6, 0, 0, 0, 0));
    exp_q.push_back(mk(0, 0, 0, 0, 0));
    exp_q.push_back(mk(1, 0, 1, 0, 0));
    for (int k = 0; k < 4; k++) begin
      if (k == 2) begin
        #3 n_rst = 1'b0;
        #1;
      end else begin
        next_edge();
      end
      got_v = {count_out, rollover_flag, floor_flag, wrap_pulse, cfg_err};
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (got_v !== exp_v) begin
        n_mis++;
        $display("FAIL reset_mid[%0d]: got cnt=%0d rf/ff/wp/ce=%b, expected cnt=%0d rf/ff/wp/ce=%b",
                 k, got_v[7:4], got_v[3:0], exp_v[7:4], exp_v[3:0]);
      end else $display("reset_mid[%0d] cnt=%0d flags=%b", k, got_v[7:4], got_v[3:0]);
      if (k == 2) begin
        next_edge();
        n_rst = 1'b1;
      end
    end
  endtask

`ifdef FLEX_CNT_PRESCALE_EN
  task automatic test_prescale();
    int cnts[15] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 0, 0, 0, 1};
    floor_val = 4'd0; rollover_val = 4'd15; step = 2'd1; count_down = DIR_UP;
    mode = MODE_WRAP; prescale_val = 4'd2; count_enable = 1'b1;
    foreach (cnts[i]) exp_q.push_back(mk(cnts[i], 0, cnts[i] == 0, 0, 0));
    for (int k = 0; k < 15; k++) begin
      clear = (k == 0) || (k == 11);
      next_edge();
      got_v = {count_out, rollover_flag, floor_flag, wrap_pulse, cfg_err};
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (got_v !== exp_v) begin
        n_mis++;
        $display("FAIL prescale[%0d]: got cnt=%0d rf/ff/wp/ce=%b, expected cnt=%0d rf/ff/wp/ce=%b",
                 k, got_v[7:4], got_v[3:0], exp_v[7:4], exp_v[3:0]);
      end else $display("prescale[%0d] cnt=%0d flags=%b", k, got_v[7:4], got_v[3:0]);
    end
    clear = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_legacy();
    test_overshoot();
    test_down();
    test_priority();
    test_cfg_err();
    test_reset_mid();
`ifdef FLEX_CNT_PRESCALE_EN
    test_prescale();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/flex_updown_counter.md
Name: flex_updown_counter

Overview:
- Parametrised successor to the team's single-direction rollover counter.
- Counts up or down by a programmable step between a programmable floor and ceiling.
- Supports wrap or saturate mode, synchronous load, and registered boundary flags.
- Used as the generic timing/index counter in datapath controllers: bit/byte counters, timeouts, FIFO pointers.

Parameters:
- NUM_CNT_BITS, 4, width of count, bounds and load value.
- STEP_BITS, 2, width of the step input.
- PRESCALE_BITS, 4, width of the prescale divider (used only with FLEX_CNT_PRESCALE_EN).

Ports:
- clk  input  1  system clock, rising edge.
- n_rst  input  1  asynchronous active-low reset.
- clear  input  1  synchronous clear of count to 0.
- load  input  1  synchronous load of load_val.
- load_val  input  NUM_CNT_BITS  value taken on load.
- count_enable  input  1  advance count this cycle.
- count_down  input  1  0 = up, 1 = down.
- mode  input  1  flex_cnt_pkg::mode_t; MODE_WRAP=0, MODE_SAT=1.
- step  input  STEP_BITS  increment/decrement amount.
- floor_val  input  NUM_CNT_BITS  lower bound; the restart value on up-wrap.
- rollover_val  input  NUM_CNT_BITS  upper bound; the restart value on down-wrap.
- prescale_val  input  PRESCALE_BITS  divider; present only with FLEX_CNT_PRESCALE_EN.
- count_out  output  NUM_CNT_BITS  current count, registered.
- rollover_flag  output  1  registered; 1 while count_out == rollover_val.
- floor_flag  output  1  registered; 1 while count_out == floor_val.
- wrap_pulse  output  1  registered one-cycle pulse on a wrap or saturation event.
- cfg_err  output  1  registered; 1 while floor_val > rollover_val.

Behaviour:
- Reset: count_out=0, rollover_flag=0, floor_flag=0, wrap_pulse=0, cfg_err=0. Asynchronous assert; outputs valid from the first clk edge after release.
- Priority: clear > load > count_enable > hold. All take effect at the next rising edge; latency is 1 cycle.
- clear: next count = 0, regardless of bounds. No wrap_pulse.
- load: next count = load_val, even if outside [floor, rollover]. No wrap_pulse.
- Step of 0: count holds, no wrap_pulse, even with count_enable=1.
- Up count, evaluated in NUM_CNT_BITS+1 bits so there is no silent overflow:
  - sum = count + step.
  - If sum > rollover_val: MODE_WRAP gives next = floor_val; MODE_SAT gives next = rollover_val. wrap_pulse=1 in both cases.
  - Remainder is discarded, not carried.
  - If count == rollover_val in MODE_SAT, the count holds and wrap_pulse=1 on every enabled cycle.
- Down count, signed NUM_CNT_BITS+1 arithmetic:
  - diff = count − step.
  - If diff < floor_val: MODE_WRAP gives next = rollover_val; MODE_SAT gives next = floor_val. wrap_pulse=1.
- Count outside bounds (after clear or load):
  - Counting up from below floor proceeds normally.
  - Counting down from above rollover proceeds normally.
  - Boundary tests use only the rules above.
- cfg_err:
  - When floor_val > rollover_val, count_enable is ignored (count holds, wrap_pulse=0).
  - clear and load still work.
  - cfg_err is registered from the compare each cycle.
- Flags: rollover_flag and floor_flag are registered from next count compares, so they align with count_out. Both may be 1 when floor_val == rollover_val.
- Mid-operation inputs: mode, step, count_down and the bounds are sampled every cycle. A change takes effect on the same edge it is seen.
- Reset mid-count returns all outputs to their reset values immediately.
- Equivalence: floor_val=1, step=1, up, MODE_WRAP reproduces the legacy counter sequence (1..N, 1..N).

Optional Feature:
- Macro: FLEX_CNT_PRESCALE_EN.
- Defined:
  - An internal prescale counter advances on each count_enable cycle.
  - The main count advances only when the prescaler reaches prescale_val; the prescaler then returns to 0.
  - prescale_val=0 means every enabled cycle.
  - clear, load and reset zero the prescaler.
  - wrap_pulse fires only on cycles where the main count actually advances.
- Undefined: the prescale_val port and the prescaler logic are absent; the count advances on every enabled cycle.

Decomposition:
- Package flex_cnt_pkg:
  - typedef enum logic {MODE_WRAP, MODE_SAT} mode_t.
  - typedef enum logic {DIR_UP, DIR_DOWN} dir_t.
  - Default width localparams.
- Sub-module flex_prescaler, instantiated only under FLEX_CNT_PRESCALE_EN. It is a PRESCALE_BITS counter with clk, n_rst, clear and enable inputs, producing a tick output.
- The remainder of the block is one always_ff plus one always_comb next-state block.

Test Plan:
- Reset and legacy mode: n_rst pulse, then floor=1, roll=5, step=1, up, WRAP, enable 12 cycles.
  - Required: count 1,2,3,4,5,1,2,...
  - rollover_flag high with 5; wrap_pulse after each 5→1 transition.
- Step overshoot and saturation: roll=10, floor=2, step=3, up from load 2.
  - WRAP sequence: 2,5,8,2 with wrap_pulse on 8→2.
  - SAT sequence: 2,5,8,10,10 with wrap_pulse on 8→10 and on each hold at 10.
- Down count: floor=3, roll=9, step=2, down, load 7.
  - WRAP sequence: 7,5,3,9.
  - SAT sequence: 7,5,3,3; floor_flag high at 3.
- Priority: clear, load and count_enable all high with load_val=6. Required: count 0.
  - Next cycle, load and count_enable high: count 6, no wrap_pulse.
- Config error: floor=8, roll=4, enabled. Required: cfg_err=1 and count holds.
  - load_val=2 still loads.
  - Restoring floor=1 clears cfg_err on the next edge.
- Prescale (FLEX_CNT_PRESCALE_EN): prescale_val=2, step=1, up, enabled from 0. Required: count increments every 3rd cycle.
  - clear mid-period restarts the 3-cycle period.
